// File: rtl/sdram_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sdram_cmd_pkg
// Shared definitions for the UART command path in front of the SDRAM
// controller: the command FSM state encoding, the default header bytes and
// the write burst length that the write path also relies on.
// ---------------------------------------------------------------------------
package sdram_cmd_pkg;

    // One-hot command decoder states.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_COLLECT = 4'b0010,
        ST_PUSH    = 4'b0100,
        ST_TRIG    = 4'b1000
    } state_e;

    // Default packet header bytes.
    localparam logic [7:0] WR_CMD_DEF = 8'h55;
    localparam logic [7:0] RD_CMD_DEF = 8'hAA;

    // Payload bytes per write burst, shared with the SDRAM write path.
    localparam int BURST_LEN = 4;

endpackage : sdram_cmd_pkg

// File: rtl/uart_cmd_decode_gap_timer.sv
// ---------------------------------------------------------------------------
// gap_timer
// Loadable saturating up-counter used to police gaps on the UART side.
// expire_o fires in the cycle whose increment brings the count to LIMIT-1,
// so the registered timeout pulse downstream lines up with the count
// reaching LIMIT-1. LIMIT must be at least 2.
//
// Ports:
//   clk         clock
//   rst         asynchronous reset, active-high (count -> 0)
//   clr_i       synchronous clear (highest priority)
//   load_i      synchronous load of load_val_i
//   load_val_i  value loaded when load_i is high
//   inc_i       count up by one, saturating at all-ones
//   expire_o    this increment reaches LIMIT-1
// ---------------------------------------------------------------------------
module gap_timer #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires only on the arrival at LIMIT-1, never again while held there.
    assign expire_o = inc_i && !clr_i && !load_i && (cnt_q != cnt_d)
                      && (cnt_d == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : gap_timer

// File: rtl/uart_cmd_decode.sv
// ---------------------------------------------------------------------------
// uart_cmd_decode
// Parses UART bytes into SDRAM commands. A WR_CMD header is followed by
// WR_LEN payload bytes which are buffered, pushed in order into the write
// FIFO and then announced with a wr_trig pulse. An RD_CMD header in IDLE
// produces an rd_trig pulse. A long gap between payload bytes aborts the
// packet; bytes that cannot be used are dropped and flagged. All outputs
// are registered.
//
// Ports:
//   sclk           system clock
//   s_rst          asynchronous reset, active-high
//   rx_flag        one-cycle strobe, rx_data valid
//   rx_data        received UART byte
//   wfifo_full     write FIFO cannot accept a byte this cycle
//   wfifo_wr_en    write strobe to the write FIFO
//   wfifo_wr_data  byte written to the FIFO
//   wr_trig        one-cycle pulse, a full write burst is in the FIFO
//   rd_trig        one-cycle pulse, start an SDRAM read burst
//   busy           high in every state except IDLE
//   err_timeout    one-cycle pulse, packet aborted by the gap timeout
//   err_drop       one-cycle pulse, a received byte was discarded
// ---------------------------------------------------------------------------
module uart_cmd_decode
    import sdram_cmd_pkg::*;
#(
    parameter logic [7:0] WR_CMD      = WR_CMD_DEF,
    parameter logic [7:0] RD_CMD      = RD_CMD_DEF,
    parameter int         WR_LEN      = BURST_LEN,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       rx_flag,
    input  logic [7:0] rx_data,
    input  logic       wfifo_full,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_wr_data,
    output logic       wr_trig,
    output logic       rd_trig,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_drop
);

    localparam int CNT_W = $clog2(WR_LEN + 1);
    localparam int GAP_W = $clog2(TIMEOUT_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [7:0]       data_buf_q [WR_LEN];

    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_trig_q, wr_trig_d;
    logic       rd_trig_q, rd_trig_d;
    logic       busy_q, busy_d;
    logic       err_to_q, err_to_d;
    logic       err_drop_q, err_drop_d;

    logic       store;
    logic [7:0] push_byte;
    logic       gap_clr, gap_inc, gap_expire;

    // Gap timer only runs in COLLECT; any byte restarts it, so a byte
    // arriving in the expiry cycle wins over the timeout.
    assign gap_clr = (state_q != ST_COLLECT) || rx_flag;
    assign gap_inc = (state_q == ST_COLLECT) && !rx_flag;

    gap_timer #(
        .WIDTH (GAP_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk        (sclk),
        .rst        (s_rst),
        .clr_i      (gap_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (gap_inc),
        .expire_o   (gap_expire)
    );

    // Buffer read mux for the push phase.
    always_comb begin
        push_byte = '0;
        for (int i = 0; i < WR_LEN; i++) begin
            if (idx_q == CNT_W'(i)) begin
                push_byte = data_buf_q[i];
            end
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        wr_trig_d  = 1'b0;
        rd_trig_d  = 1'b0;
        err_to_d   = 1'b0;
        err_drop_d = 1'b0;
        store      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_flag) begin
                    if (rx_data == WR_CMD) begin
                        state_d = ST_COLLECT;
                        cnt_d   = '0;
                    end else if (rx_data == RD_CMD) begin
                        rd_trig_d = 1'b1;
                    end else begin
                        err_drop_d = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                // Header values are ordinary payload here.
                if (rx_flag) begin
                    store = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WR_LEN - 1)) begin
                        state_d = ST_PUSH;
                        idx_d   = '0;
                    end
                end else if (gap_expire) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            ST_PUSH: begin
                err_drop_d = rx_flag;
                // A full FIFO stalls the push for as long as it stays full.
                if (!wfifo_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = push_byte;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == CNT_W'(WR_LEN - 1)) begin
                        state_d = ST_TRIG;
                    end
                end
            end

            ST_TRIG: begin
                err_drop_d = rx_flag;
                wr_trig_d  = 1'b1;
                state_d    = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // busy is registered from the next state so it tracks state_q exactly.
    assign busy_d = (state_d != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_trig_q  <= 1'b0;
            rd_trig_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            wr_trig_q  <= wr_trig_d;
            rd_trig_q  <= rd_trig_d;
            busy_q     <= busy_d;
            err_to_q   <= err_to_d;
            err_drop_q <= err_drop_d;
        end
    end

    // NOTE: the payload buffer has no reset; every entry is written in
    // COLLECT before PUSH reads it, so its power-up contents never matter.
    always_ff @(posedge sclk) begin
        if (store) begin
            for (int i = 0; i < WR_LEN; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    data_buf_q[i] <= rx_data;
                end
            end
        end
    end

    assign wfifo_wr_en   = wr_en_q;
    assign wfifo_wr_data = wr_data_q;
    assign wr_trig       = wr_trig_q;
    assign rd_trig       = rd_trig_q;
    assign busy          = busy_q;
    assign err_timeout   = err_to_q;
    assign err_drop      = err_drop_q;

endmodule : uart_cmd_decode

// File: tb/tb_uart_cmd_decode.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_decode
// Directed bench for uart_cmd_decode with WR_LEN=4 and TIMEOUT_CYC=100.
// Output events are logged with their cycle number on the falling edge and
// compared against hand-computed cycles and data.
// ---------------------------------------------------------------------------
module tb_uart_cmd_decode;

    localparam int TO = 100;

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic       rx_flag = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wfifo_full = 1'b0;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_wr_data;
    logic       wr_trig;
    logic       rd_trig;
    logic       busy;
    logic       err_timeout;
    logic       err_drop;

    uart_cmd_decode #(
        .WR_CMD      (8'h55),
        .RD_CMD      (8'hAA),
        .WR_LEN      (4),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sclk          (sclk),
        .s_rst         (s_rst),
        .rx_flag       (rx_flag),
        .rx_data       (rx_data),
        .wfifo_full    (wfifo_full),
        .wfifo_wr_en   (wfifo_wr_en),
        .wfifo_wr_data (wfifo_wr_data),
        .wr_trig       (wr_trig),
        .rd_trig       (rd_trig),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_drop      (err_drop)
    );

    always #5 sclk = ~sclk;

    // cyc holds n throughout the cycle that follows the n-th rising edge.
    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_cyc = 0;
    int both_hi = 0;

    int w_cyc[$];
    int w_dat[$];
    int wt_cyc[$];
    int rt_cyc[$];
    int to_cyc[$];
    int dr_cyc[$];

    always @(negedge sclk) begin
        if (!s_rst) begin
            if (wfifo_wr_en) begin
                w_cyc.push_back(cyc);
                w_dat.push_back(int'(wfifo_wr_data));
            end
            if (wr_trig)     wt_cyc.push_back(cyc);
            if (rd_trig)     rt_cyc.push_back(cyc);
            if (err_timeout) to_cyc.push_back(cyc);
            if (err_drop)    dr_cyc.push_back(cyc);
            if (wr_trig && rd_trig) both_hi++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue element or -1 when the index is out of range.
    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Present one byte for one cycle; call right after tick().
    task automatic send(input logic [7:0] b);
        rx_flag  = 1'b1;
        rx_data  = b;
        last_cyc = cyc;
        tick();
        rx_flag  = 1'b0;
    endtask

    task automatic clear_logs();
        w_cyc.delete();
        w_dat.delete();
        wt_cyc.delete();
        rt_cyc.delete();
        to_cyc.delete();
        dr_cyc.delete();
    endtask

    function automatic int outs();
        return int'({busy, wfifo_wr_en, wr_trig, rd_trig, err_timeout,
                     err_drop, wfifo_wr_data});
    endfunction

    int c;
    int d;

    initial begin
        // ---------------- reset state ----------------
        idle(3);
        check("reset_outputs", outs(), 0);
        s_rst = 1'b0;
        tick();
        check("idle_busy", int'(busy), 0);

        // ---------------- 1: basic write packet ----------------
        clear_logs();
        send(8'h55); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        c = last_cyc;
        check("t1_busy_in_push", int'(busy), 1);
        idle(10);
        check("t1_wr_count", w_dat.size(), 4);
        check("t1_d0", at(w_dat, 0), 'h11);
        check("t1_d1", at(w_dat, 1), 'h22);
        check("t1_d2", at(w_dat, 2), 'h33);
        check("t1_d3", at(w_dat, 3), 'h44);
        check("t1_first_wr_cyc", at(w_cyc, 0), c + 2);
        check("t1_last_wr_cyc", at(w_cyc, 3), c + 5);
        check("t1_trig_count", wt_cyc.size(), 1);
        check("t1_trig_cyc", at(wt_cyc, 0), c + 6);
        check("t1_no_rd", rt_cyc.size(), 0);
        check("t1_busy_done", int'(busy), 0);

        // ---------------- 2: read command ----------------
        clear_logs();
        send(8'hAA);
        c = last_cyc;
        idle(5);
        check("t2_rd_count", rt_cyc.size(), 1);
        check("t2_rd_cyc", at(rt_cyc, 0), c + 1);
        check("t2_no_wr", w_dat.size(), 0);
        check("t2_busy", int'(busy), 0);

        // ---------------- 3: gap timeout ----------------
        clear_logs();
        send(8'h55); send(8'h11); send(8'h22);
        c = last_cyc;
        idle(TO + 10);
        check("t3_to_count", to_cyc.size(), 1);
        check("t3_to_cyc", at(to_cyc, 0), c + TO);
        check("t3_no_wr", w_dat.size(), 0);
        check("t3_no_trig", wt_cyc.size(), 0);
        check("t3_busy", int'(busy), 0);
        clear_logs();
        send(8'hAA);
        idle(3);
        check("t3_rd_after", rt_cyc.size(), 1);

        // ---------------- 4: FIFO stall on push cycles 2 and 3 ----------------
        clear_logs();
        send(8'h55); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        c = last_cyc;
        tick();
        wfifo_full = 1'b1;
        tick();
        tick();
        wfifo_full = 1'b0;
        idle(10);
        check("t4_wr_count", w_dat.size(), 4);
        check("t4_d0", at(w_dat, 0), 'h01);
        check("t4_d1", at(w_dat, 1), 'h02);
        check("t4_d2", at(w_dat, 2), 'h03);
        check("t4_d3", at(w_dat, 3), 'h04);
        check("t4_wr0_cyc", at(w_cyc, 0), c + 2);
        check("t4_wr1_cyc", at(w_cyc, 1), c + 5);
        check("t4_wr3_cyc", at(w_cyc, 3), c + 7);
        check("t4_trig_cyc", at(wt_cyc, 0), c + 8);

        // ---------------- 5: drops and header-as-data ----------------
        clear_logs();
        send(8'h7F);
        c = last_cyc;
        idle(3);
        check("t5_drop_idle_count", dr_cyc.size(), 1);
        check("t5_drop_idle_cyc", at(dr_cyc, 0), c + 1);
        check("t5_no_rd", rt_cyc.size(), 0);
        clear_logs();
        send(8'h55); send(8'hAA); send(8'h12); send(8'h34); send(8'h56);
        tick();
        send(8'hAA);
        d = last_cyc;
        idle(8);
        check("t5_drop_push_count", dr_cyc.size(), 1);
        check("t5_drop_push_cyc", at(dr_cyc, 0), d + 1);
        check("t5_no_rd_in_push", rt_cyc.size(), 0);
        check("t5_wr_count", w_dat.size(), 4);
        check("t5_d0_hdr_as_data", at(w_dat, 0), 'hAA);
        check("t5_d3", at(w_dat, 3), 'h56);
        check("t5_trig_count", wt_cyc.size(), 1);

        // ---------------- 6: reset mid-packet ----------------
        clear_logs();
        send(8'h55); send(8'hB1); send(8'hB2);
        check("t6_busy_collect", int'(busy), 1);
        s_rst = 1'b1;
        #1;
        check("t6_async_reset", outs(), 0);
        tick();
        s_rst = 1'b0;
        tick();
        send(8'h55); send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        idle(8);
        check("t6_wr_count", w_dat.size(), 4);
        check("t6_d0", at(w_dat, 0), 'hA1);
        check("t6_d1", at(w_dat, 1), 'hA2);
        check("t6_d2", at(w_dat, 2), 'hA3);
        check("t6_d3", at(w_dat, 3), 'hA4);
        check("t6_trig_count", wt_cyc.size(), 1);

        check("trig_overlap", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_cmd_decode
